// File: rtl/syn_cmplx_abs.sv
// Complex magnitude: floor(sqrt(re^2 + im^2)) computed by a bit-serial integer
// square root, one result bit per cycle, with a valid/ready handshake on both sides.
module syn_cmplx_abs #(
   parameter int DATA_W = 16,
   parameter int TAG_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_re,
   input  logic signed [DATA_W-1:0] in_im,
   input  logic        [TAG_W-1:0]  in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic        [DATA_W-1:0] out_abs,
   output logic        [TAG_W-1:0]  out_tag
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int RAD_W = 2 * DATA_W;
   localparam int REM_W = DATA_W + 2;

   typedef enum logic [1:0] {IDLE, SQR, ROOT, DONE} stateT;

   stateT                     state;
   logic signed [DATA_W-1:0]  reReg;
   logic signed [DATA_W-1:0]  imReg;
   logic        [TAG_W-1:0]   tagReg;
   logic        [RAD_W-1:0]   radicand;
   logic        [DATA_W-1:0]  root;
   logic        [REM_W-1:0]   remainder;
   logic        [CNT_W-1:0]   count;

   logic signed [RAD_W-1:0]   reExt;
   logic signed [RAD_W-1:0]   imExt;
   logic        [RAD_W-1:0]   sumSq;
   logic        [REM_W-1:0]   remShift;
   logic        [REM_W-1:0]   trial;
   logic                      bitSet;
   logic        [DATA_W-1:0]  rootNext;

   // Sign-extending to the full radicand width first keeps (-2^(W-1))^2 exact;
   // the sum of two such squares only fits when treated as unsigned.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      reExt    = RAD_W'(reReg);
      imExt    = RAD_W'(imReg);
      sumSq    = $unsigned(reExt * reExt) + $unsigned(imExt * imExt);
      remShift = {remainder[DATA_W-1:0], radicand[RAD_W-1 -: 2]};
      trial    = {root, 2'b01};
      bitSet   = (remShift >= trial);
      rootNext = {root[DATA_W-2:0], bitSet};
   end

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_abs   <= '0;
         out_tag   <= '0;
         reReg     <= '0;
         imReg     <= '0;
         tagReg    <= '0;
         radicand  <= '0;
         root      <= '0;
         remainder <= '0;
         count     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  reReg    <= in_re;
                  imReg    <= in_im;
                  tagReg   <= in_tag;
                  in_ready <= 1'b0;
                  state    <= SQR;
               end
            end
            SQR: begin
               radicand  <= sumSq;
               root      <= '0;
               remainder <= '0;
               count     <= CNT_W'(DATA_W - 1);
               state     <= ROOT;
            end
            ROOT: begin
               // Consume the top two radicand bits per step, restoring-style digit recurrence.
               radicand  <= radicand << 2;
               remainder <= bitSet ? (remShift - trial) : remShift;
               root      <= rootNext;
               if (count == '0) begin
                  out_abs   <= rootNext;
                  out_tag   <= tagReg;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  count <= count - CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_syn_cmplx_abs.sv
// Self-checking bench for syn_cmplx_abs: vector table, handshake/reset corner
// sequences, and randomized traffic against an arithmetic sqrt reference.
module tb_syn_cmplx_abs;

   localparam int DATA_W = 16;
   localparam int TAG_W  = 8;
   localparam int LAT    = DATA_W + 1;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_re;
   logic signed [DATA_W-1:0] in_im;
   logic        [TAG_W-1:0]  in_tag;
   logic                     out_valid;
   logic                     out_ready;
   logic        [DATA_W-1:0] out_abs;
   logic        [TAG_W-1:0]  out_tag;

   int checks   = 0;
   int failures = 0;

   syn_cmplx_abs #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_re     (in_re),
      .in_im     (in_im),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_abs   (out_abs),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic signed [DATA_W-1:0] re;
      logic signed [DATA_W-1:0] im;
      logic        [TAG_W-1:0]  tag;
      int                       expAbs;
      int                       stalls;
   } vecT;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Reference magnitude straight from the definition: floor of the real square root.
   function automatic int syn_calc_abs(input int re, input int im);
      longint s;
      longint r;
      s = longint'(re) * re + longint'(im) * im;
      r = longint'($floor($sqrt(real'(s))));
      while (r * r > s) r--;
      while ((r + 1) * (r + 1) <= s) r++;
      return int'(r);
   endfunction

   task automatic scramble();
      in_re  = DATA_W'($urandom);
      in_im  = DATA_W'($urandom);
      in_tag = TAG_W'($urandom);
   endtask

   task automatic doTxn(input logic signed [DATA_W-1:0] re, input logic signed [DATA_W-1:0] im,
                        input logic [TAG_W-1:0] tag, input int expAbs, input int stalls,
                        input string name);
      int waitCyc;
      int lat;
      logic busyReady;
      logic stallBad;
      logic [DATA_W-1:0] heldAbs;
      waitCyc = 0;
      while (!in_ready && waitCyc < 100) begin
         @(negedge clk);
         waitCyc++;
      end
      if (waitCyc >= 100) begin
         check({name, "_ready_timeout"}, 64'(in_ready), 64'd1);
         return;
      end
      out_ready = (stalls == 0);
      in_re     = re;
      in_im     = im;
      in_tag    = tag;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid  = 1'b0;
      scramble();
      lat = 0;
      busyReady = 1'b0;
      while (!out_valid && lat < 60) begin
         busyReady |= in_ready;
         @(negedge clk);
         lat++;
         scramble();
      end
      check({name, "_latency"}, 64'(lat), 64'(LAT));
      check({name, "_busy_in_ready"}, 64'(busyReady), 64'd0);
      if (!out_valid) return;
      heldAbs  = out_abs;
      stallBad = 1'b0;
      for (int s = 0; s < stalls; s++) begin
         @(negedge clk);
         if (!out_valid || out_abs !== heldAbs || in_ready) stallBad = 1'b1;
      end
      if (stalls > 0) check({name, "_hold"}, 64'(stallBad), 64'd0);
      out_ready = 1'b1;
      check({name, "_abs"}, 64'(out_abs), 64'(expAbs));
      check({name, "_tag"}, 64'(out_tag), 64'(tag));
      @(negedge clk);
      check({name, "_valid_drop"}, 64'(out_valid), 64'd0);
      check({name, "_ready_back"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecT vecs[12];
      typedef struct {
         logic signed [DATA_W-1:0] re;
         logic signed [DATA_W-1:0] im;
         logic        [TAG_W-1:0]  tag;
         int                       expAbs;
      } b2bT;
      b2bT b2b[3];
      int acceptCyc[3];
      int sent;
      int got;
      int cyc;
      int guard;
      logic sawValid;
      logic signed [DATA_W-1:0] rre;
      logic signed [DATA_W-1:0] rim;

      vecs[0]  = '{re:  16'sd3,     im:  16'sd4,     tag: 8'h11, expAbs: 5,     stalls: 0};
      vecs[1]  = '{re: -16'sd32768, im: -16'sd32768, tag: 8'h22, expAbs: 46340, stalls: 0};
      vecs[2]  = '{re:  16'sd0,     im:  16'sd0,     tag: 8'h33, expAbs: 0,     stalls: 0};
      vecs[3]  = '{re:  16'sd1,     im:  16'sd1,     tag: 8'h44, expAbs: 1,     stalls: 0};
      vecs[4]  = '{re: -16'sd5,     im:  16'sd12,    tag: 8'h55, expAbs: 13,    stalls: 10};
      vecs[5]  = '{re:  16'sd5,     im: -16'sd12,    tag: 8'h66, expAbs: 13,    stalls: 0};
      vecs[6]  = '{re:  16'sd12,    im:  16'sd5,     tag: 8'h77, expAbs: 13,    stalls: 2};
      vecs[7]  = '{re:  16'sd32767, im:  16'sd32767, tag: 8'h88, expAbs: 46339, stalls: 0};
      vecs[8]  = '{re: -16'sd32768, im:  16'sd0,     tag: 8'h99, expAbs: 32768, stalls: 0};
      vecs[9]  = '{re:  16'sd0,     im: -16'sd32768, tag: 8'hAA, expAbs: 32768, stalls: 1};
      vecs[10] = '{re:  16'sd6,     im:  16'sd8,     tag: 8'hBB, expAbs: 10,    stalls: 0};
      vecs[11] = '{re: -16'sd1,     im:  16'sd0,     tag: 8'hFF, expAbs: 1,     stalls: 0};

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      scramble();
      repeat (3) @(negedge clk);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_out_abs", 64'(out_abs), 64'd0);
      check("reset_out_tag", 64'(out_tag), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 12; i++)
         doTxn(vecs[i].re, vecs[i].im, vecs[i].tag, vecs[i].expAbs, vecs[i].stalls,
               $sformatf("vec%0d", i));

      // Back-to-back: in_valid never drops, accepts must be one initiation interval apart.
      b2b[0] = '{re:  16'sd3,  im:  16'sd4,   tag: 8'hA1, expAbs: 5};
      b2b[1] = '{re: -16'sd8,  im:  16'sd15,  tag: 8'hA2, expAbs: 17};
      b2b[2] = '{re:  16'sd20, im: -16'sd21,  tag: 8'hA3, expAbs: 29};
      out_ready = 1'b1;
      sent = 0;
      got = 0;
      cyc = 0;
      while (got < 3 && cyc < 200) begin
         if (sent < 3) begin
            in_re = b2b[sent].re;
            in_im = b2b[sent].im;
            in_tag = b2b[sent].tag;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         if (out_valid) begin
            check($sformatf("b2b%0d_abs", got), 64'(out_abs), 64'(b2b[got].expAbs));
            check($sformatf("b2b%0d_tag", got), 64'(out_tag), 64'(b2b[got].tag));
            got++;
         end
         if (in_ready && sent < 3) begin
            acceptCyc[sent] = cyc;
            sent++;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      check("b2b_results", 64'(got), 64'd3);
      if (sent == 3) begin
         check("b2b_gap01", 64'(acceptCyc[1] - acceptCyc[0]), 64'(DATA_W + 3));
         check("b2b_gap12", 64'(acceptCyc[2] - acceptCyc[1]), 64'(DATA_W + 3));
      end else begin
         check("b2b_accepts", 64'(sent), 64'd3);
      end

      // Reset during the 8th root iteration discards the sample.
      in_re = 16'sd100;
      in_im = 16'sd200;
      in_tag = 8'h5A;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_root_out_valid", 64'(out_valid), 64'd0);
      check("rst_root_in_ready", 64'(in_ready), 64'd1);
      doTxn(16'sd6, 16'sd8, 8'h68, 10, 0, "after_rst_root");

      // Reset wins over an accept on the same edge.
      rst = 1'b1;
      in_valid = 1'b1;
      in_re = 16'sd9;
      in_im = 16'sd40;
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      check("rst_accept_in_ready", 64'(in_ready), 64'd1);
      sawValid = 1'b0;
      repeat (LAT + 4) begin
         @(negedge clk);
         sawValid |= out_valid;
      end
      check("rst_accept_no_result", 64'(sawValid), 64'd0);

      // Reset in DONE while stalled clears the result registers.
      out_ready = 1'b0;
      in_re = 16'sd7;
      in_im = 16'sd24;
      in_tag = 8'hC3;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      guard = 0;
      while (!out_valid && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      check("rst_done_abs_before", 64'(out_abs), 64'd25);
      rst = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_done_out_valid", 64'(out_valid), 64'd0);
      check("rst_done_out_abs", 64'(out_abs), 64'd0);
      check("rst_done_out_tag", 64'(out_tag), 64'd0);
      check("rst_done_in_ready", 64'(in_ready), 64'd1);

      // Randomized traffic with idle gaps and downstream backpressure.
      for (int i = 0; i < 1500; i++) begin
         rre = ($urandom_range(0, 15) == 0) ? -16'sd32768 : DATA_W'($urandom);
         rim = ($urandom_range(0, 15) == 0) ? -16'sd32768 : DATA_W'($urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         doTxn(rre, rim, TAG_W'($urandom), syn_calc_abs(rre, rim),
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
               $sformatf("rand%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
